uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one UART transmitter among `NUM_REQ` byte producers. It accepts one byte at a time from a requester through a valid/ready handshake. It launches the frame with a single-cycle data-valid pulse, selects parity per frame, and tracks the transmitter's busy flag until the frame completes. It sits between the system-side producers and the UART TX core (FSM + serializer + parity + mux), driving that core's `Data_Valid`, `P_DATA` and `PAR_EN` inputs.

---
 rtl/uart_tx_arbiter_if.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester handshake plus UART TX core launch/status signals.
// The arbiter connects through the master modport. The producers and the TX core
// connect through the slave modport.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int GW = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_par_en;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          tx_busy;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic                          tx_par_en;
    logic                          tx_data_valid;
    logic [GW-1:0]                 grant_id;
    logic                          arb_busy;
    logic                          err_timeout;

    modport master (
        input  req_valid, req_data, req_par_en, tx_busy,
        output req_ready, tx_data, tx_par_en, tx_data_valid, grant_id, arb_busy, err_timeout
    );

    modport slave (
        output req_valid, req_data, req_par_en, tx_busy,
        input  req_ready, tx_data, tx_par_en, tx_data_valid, grant_id, arb_busy, err_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART TX core among NUM_REQ
// byte producers. It accepts one byte, pulses the launch, and follows tx_busy
// until the frame completes. It then enforces an idle gap before the next grant.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int GAP_CYCLES    = 2,
    parameter int START_TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    uart_tx_arbiter_if.master       bus
);
    localparam int GW       = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_MAX  = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
    localparam int CW       = ($clog2(CNT_MAX + 1) > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [CW-1:0] TO_LAST  = CW'(START_TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_LAST_I);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_START,
        WAIT_DONE,
        GAP
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [GW-1:0]         ptr_q, ptr_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_q, par_d;

    logic [NUM_REQ-1:0]    ready_c;
    logic                  dv_c;
    logic                  err_c;

    logic                  any_valid;
    logic [GW-1:0]         winner;
    logic [GW-1:0]         cand;
    logic [DATA_WIDTH-1:0] req_bytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
        assign req_bytes[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Scan from the requester after the last winner, with wrap, for the first valid one.
    always_comb begin
        any_valid = 1'b0;
        winner    = ptr_q;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((int'(ptr_q) + k) % NUM_REQ);
            if (!any_valid && bus.req_valid[cand]) begin
                any_valid = 1'b1;
                winner    = cand;
            end
        end
    end

    // Next state, counter and latch updates, and the one-cycle strobes.
    // The strobes are forced low while rst is high so no transfer happens during reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        data_d  = data_q;
        par_d   = par_q;
        ready_c = '0;
        dv_c    = 1'b0;
        err_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!bus.tx_busy && any_valid) begin
                    ready_c[winner] = 1'b1;
                    data_d          = req_bytes[winner];
                    par_d           = bus.req_par_en[winner];
                    grant_d         = winner;
                    ptr_d           = winner;
                    state_d         = LAUNCH;
                end
            end
            LAUNCH: begin
                dv_c    = 1'b1;
                cnt_d   = '0;
                state_d = WAIT_START;
            end
            WAIT_START: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == TO_LAST) begin
                    err_c   = 1'b1;
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (rst) begin
            ready_c = '0;
            dv_c    = 1'b0;
            err_c   = 1'b0;
        end
    end

    // State register and latched frame attributes. On reset, requester 0 gets first priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= GW'(NUM_REQ - 1);
            grant_q <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            par_q   <= par_d;
        end
    end

    assign bus.req_ready     = ready_c;
    assign bus.tx_data       = data_q;
    assign bus.tx_par_en     = par_q;
    assign bus.tx_data_valid = dv_c;
    assign bus.grant_id      = grant_q;
    assign bus.arb_busy      = (state_q != IDLE);
    assign bus.err_timeout   = err_c;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed steps plus a randomized phase. Each phase is checked
// against a frame-timing reference model that works in cycle numbers.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DW      = 8;
    localparam int GAP     = 2;
    localparam int ST      = 15;
    localparam int GAPMIN  = (GAP > 1) ? GAP : 1;

    logic clk;
    logic rst;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .GAP_CYCLES(GAP), .START_TIMEOUT(ST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nVec = 0;
    int nMis = 0;
    int cyc  = 0;
    bit prevRst = 1'b0;

    bit coreEn    = 1'b1;
    bit forceBusy = 1'b0;
    int coreStart = -100;
    int coreEnd   = -100;

    bit         mOpen;
    bit         mSawBusy;
    int         mIdleFrom;
    int         mLaunch;
    int         mLast;
    logic [7:0] mData;
    logic       mPar;
    logic [1:0] mGrant;

    logic [3:0] obsReady;
    logic       obsDv;
    logic       obsErr;
    int         obsGrants[$];

    logic [7:0] drvData [4];
    logic [3:0] drvPar;

    bit got;
    int errCount;
    int dvCount;
    int errIdx;
    int expOrder [6] = '{0, 1, 2, 3, 0, 1};

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nMis++;
            $error("[TB] FAIL %s: observed 0x%0h required 0x%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input bit rstIn, input bit randData);
        logic       busyNow;
        logic [3:0] expReady;
        logic       expDv;
        logic       expErr;
        bit         idle;
        bit         accept;
        int         w;
        int         idx;
        logic [1:0] wi;
        @(negedge clk);
        if (randData) begin
            for (int i = 0; i < 4; i++) drvData[i] = 8'($urandom);
            drvPar = 4'($urandom);
        end
        rst            = rstIn;
        bus.req_valid  = valid;
        bus.req_data   = {drvData[3], drvData[2], drvData[1], drvData[0]};
        bus.req_par_en = drvPar;
        busyNow        = forceBusy || (cyc >= coreStart && cyc <= coreEnd);
        bus.tx_busy    = busyNow;
        #1;
        obsReady = bus.req_ready;
        obsDv    = bus.tx_data_valid;
        obsErr   = bus.err_timeout;
        if (!rstIn) begin
            for (int i = 0; i < 4; i++) if (obsReady[i]) obsGrants.push_back(i);
        end

        if (rstIn) begin
            checkOutput("rst_ready", 32'(obsReady), 32'h0);
            checkOutput("rst_dv", 32'(obsDv), 32'h0);
            checkOutput("rst_err", 32'(obsErr), 32'h0);
            if (prevRst) begin
                checkOutput("rst_arb_busy", 32'(bus.arb_busy), 32'h0);
                checkOutput("rst_tx_data", 32'(bus.tx_data), 32'h0);
                checkOutput("rst_par", 32'(bus.tx_par_en), 32'h0);
                checkOutput("rst_grant", 32'(bus.grant_id), 32'h0);
            end
            mOpen = 1'b0; mSawBusy = 1'b0; mIdleFrom = cyc + 1; mLast = NUM_REQ - 1;
            mData = '0; mPar = 1'b0; mGrant = '0;
        end else begin
            idle = !mOpen && (cyc >= mIdleFrom);
            checkOutput("arb_busy", 32'(bus.arb_busy), 32'(!idle));
            checkOutput("tx_data", 32'(bus.tx_data), 32'(mData));
            checkOutput("tx_par_en", 32'(bus.tx_par_en), 32'(mPar));
            checkOutput("grant_id", 32'(bus.grant_id), 32'(mGrant));
            expReady = '0;
            expDv    = mOpen && (cyc == mLaunch);
            expErr   = 1'b0;
            accept   = 1'b0;
            wi       = '0;
            if (mOpen && cyc > mLaunch) begin
                if (!mSawBusy) begin
                    if (busyNow) begin
                        mSawBusy = 1'b1;
                    end else if (cyc == mLaunch + ST) begin
                        expErr = 1'b1;
                        mOpen = 1'b0;
                        mIdleFrom = cyc + 1 + GAPMIN;
                    end
                end else if (!busyNow) begin
                    mOpen = 1'b0;
                    mIdleFrom = cyc + 1 + GAPMIN;
                end
            end
            if (idle && !busyNow && valid != 4'b0) begin
                w = -1;
                for (int k = 1; k <= NUM_REQ; k++) begin
                    idx = (mLast + k) % NUM_REQ;
                    if (w < 0 && valid[idx[1:0]]) w = idx;
                end
                wi = w[1:0];
                expReady[wi] = 1'b1;
                accept = 1'b1;
            end
            checkOutput("req_ready", 32'(obsReady), 32'(expReady));
            checkOutput("tx_data_valid", 32'(obsDv), 32'(expDv));
            checkOutput("err_timeout", 32'(obsErr), 32'(expErr));
            if (accept) begin
                mData = drvData[wi]; mPar = drvPar[wi]; mGrant = wi; mLast = w;
                mOpen = 1'b1; mLaunch = cyc + 1; mSawBusy = 1'b0;
            end
        end

        if (obsDv === 1'b1 && coreEn) begin
            coreStart = cyc + 1;
            coreEnd   = cyc + 11;
        end
        prevRst = rstIn;
        cyc++;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(4'b0000, 1'b0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) drvData[i] = '0;
        drvPar = '0;
        rst = 1'b1;
        bus.req_valid = '0; bus.req_data = '0; bus.req_par_en = '0; bus.tx_busy = 1'b0;
        $display("[TB] start");

        // Reset with all requesters valid, then fairness under continuous requests
        for (int i = 0; i < 3; i++) applyStimulus(4'b1111, 1'b1, 1'b1);
        obsGrants.delete();
        for (int i = 0; i < 200 && obsGrants.size() < 6; i++) applyStimulus(4'b1111, 1'b0, 1'b1);
        checkOutput("fair_count", 32'(obsGrants.size() >= 6), 32'h1);
        for (int i = 0; i < 6 && i < obsGrants.size(); i++)
            checkOutput($sformatf("fair_order%0d", i), 32'(obsGrants[i]), 32'(expOrder[i]));
        idleCycles(20);

        // Single request from requester 2 with a fixed byte
        drvData[2] = 8'hA5; drvPar = 4'b0100;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            applyStimulus(4'b0100, 1'b0, 1'b0);
            if (obsReady != 4'b0) got = 1'b1;
        end
        checkOutput("single_granted", 32'(got), 32'h1);
        checkOutput("single_ready", 32'(obsReady), 32'h4);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("single_dv", 32'(obsDv), 32'h1);
        checkOutput("single_data", 32'(bus.tx_data), 32'hA5);
        checkOutput("single_par", 32'(bus.tx_par_en), 32'h1);
        checkOutput("single_grant", 32'(bus.grant_id), 32'h2);
        idleCycles(20);

        // Timeout: the core never raises busy
        coreEn = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            applyStimulus(4'b0001, 1'b0, 1'b1);
            if (obsReady != 4'b0) got = 1'b1;
        end
        checkOutput("to_granted", 32'(got), 32'h1);
        errCount = 0; dvCount = 0; errIdx = -1;
        for (int i = 0; i < 22; i++) begin
            applyStimulus(4'b0000, 1'b0, 1'b1);
            if (obsErr === 1'b1) begin errCount++; errIdx = i; end
            if (obsDv === 1'b1) dvCount++;
        end
        checkOutput("to_pulses", 32'(errCount), 32'h1);
        checkOutput("to_launches", 32'(dvCount), 32'h1);
        checkOutput("to_latency", 32'(errIdx), 32'd15);
        coreEn = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            applyStimulus(4'b1011, 1'b0, 1'b1);
            if (obsReady != 4'b0) got = 1'b1;
        end
        checkOutput("to_next_granted", 32'(got), 32'h1);
        checkOutput("to_next_ready", 32'(obsReady), 32'h2);
        idleCycles(20);

        // External busy while idle blocks the grant until it drops
        forceBusy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(4'b0001, 1'b0, 1'b1);
            checkOutput("ext_hold", 32'(obsReady), 32'h0);
        end
        forceBusy = 1'b0;
        applyStimulus(4'b0001, 1'b0, 1'b1);
        checkOutput("ext_release", 32'(obsReady), 32'h1);
        idleCycles(20);

        // Reset in the middle of a frame
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            applyStimulus(4'b0100, 1'b0, 1'b1);
            if (obsReady != 4'b0) got = 1'b1;
        end
        checkOutput("mid_granted", 32'(got), 32'h1);
        idleCycles(6);
        applyStimulus(4'b1111, 1'b1, 1'b1);
        applyStimulus(4'b1111, 1'b0, 1'b1);
        checkOutput("mid_arb_busy", 32'(bus.arb_busy), 32'h0);
        checkOutput("mid_tx_data", 32'(bus.tx_data), 32'h0);
        checkOutput("mid_grant", 32'(bus.grant_id), 32'h0);
        got = (obsReady != 4'b0);
        for (int i = 0; i < 40 && !got; i++) begin
            applyStimulus(4'b1111, 1'b0, 1'b1);
            if (obsReady != 4'b0) got = 1'b1;
        end
        checkOutput("mid_next_granted", 32'(got), 32'h1);
        checkOutput("mid_next_ready", 32'(obsReady), 32'h1);
        idleCycles(20);

        // Randomized traffic with core stalls, forced busy and occasional resets
        for (int i = 0; i < 700; i++) begin
            if (($urandom % 40) == 0) coreEn = !coreEn;
            if (($urandom % 25) == 0) forceBusy = !forceBusy;
            applyStimulus(4'($urandom), (($urandom % 150) == 0), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end
endmodule
